// File: rtl/bin2bcd_seq_pkg.sv
// Shared display definitions for the binary-to-BCD front end of the 7-segment driver.
// Holds digit constants, the converter state encoding and the packed display width.
package bin2bcd_seq_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_ERR = 4'hE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Packed display word: one dot bit plus one BCD digit per position.
    function automatic int disp_width(input int digits);
        return 5 * digits;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the next shift.
// The result never exceeds 12, so the 4-bit add needs no carry out.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the 7-segment driver.
// Produces {dots, bcd} with a start/busy/done handshake and a fixed IN_BITS+1 edge latency.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int IN_BITS = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [IN_BITS-1:0]             bin_in,
    input  logic [DIGITS-1:0]              dots_in,
    output logic                           busy,
    output logic                           done,
    output logic                           ovf,
    output logic [disp_width(DIGITS)-1:0]  data_out
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(IN_BITS + 1);
    localparam logic [IN_BITS-1:0] MAX_BIN    = IN_BITS'(MAX_VAL);
    localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(IN_BITS - 1);

    state_t                     state, next_state;
    logic [IN_BITS-1:0]         bin_sr;
    logic [BCD_W-1:0]           bcd_sr;
    logic [BCD_W-1:0]           bcd_adj;
    logic [BCD_W+IN_BITS-1:0]   shifted;
    logic [DIGITS-1:0]          dots_reg;
    logic [CNT_W-1:0]           cnt;
    logic                       ovf_pending;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (cnt == LAST_SHIFT) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_sr [g*DIGIT_W +: DIGIT_W]),
            .q (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Adjusted digits and the binary remainder shift together as one register.
    assign shifted = {bcd_adj, bin_sr} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr      <= '0;
            bcd_sr      <= '0;
            dots_reg    <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
            data_out    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr      <= bin_in;
                        dots_reg    <= dots_in;
                        bcd_sr      <= '0;
                        cnt         <= '0;
                        ovf_pending <= (bin_in > MAX_BIN);
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd_sr <= shifted[BCD_W+IN_BITS-1:IN_BITS];
                    bin_sr <= shifted[IN_BITS-1:0];
                    cnt    <= cnt + CNT_W'(1);
                end
                COMMIT: begin
                    // Out-of-range input always shows the error pattern, whatever the shifter produced.
                    if (ovf_pending) data_out <= {{DIGITS{1'b1}}, {DIGITS{DIGIT_ERR}}};
                    else             data_out <= {dots_reg, bcd_sr};
                    ovf  <= ovf_pending;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus randomized values
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    localparam int IN_BITS = 14;
    localparam int DIGITS  = 4;
    localparam int MAX_VAL = 9999;
    localparam int OUT_W   = 5 * DIGITS;
    localparam int LATENCY = IN_BITS + 1;
    localparam int PERIOD  = IN_BITS + 2;
    localparam int BUDGET  = 60;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [IN_BITS-1:0] bin_in = '0;
    logic [DIGITS-1:0]  dots_in = '0;
    logic               busy, done, ovf;
    logic [OUT_W-1:0]   data_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.IN_BITS(IN_BITS), .DIGITS(DIGITS), .MAX_VAL(MAX_VAL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .dots_in  (dots_in),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .data_out (data_out)
    );

    // Reference: {ovf, data_out} from decimal division, or the error pattern above MAX_VAL.
    function automatic logic [OUT_W:0] model(input int unsigned value, input logic [DIGITS-1:0] dots);
        logic [OUT_W-1:0] word;
        int unsigned v;
        word = '0;
        if (value > MAX_VAL) begin
            for (int i = 0; i < DIGITS; i++) begin
                word[4*i +: 4]        = 4'hE;
                word[4*DIGITS + i]    = 1'b1;
            end
            return {1'b1, word};
        end
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            word[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        word[OUT_W-1 -: DIGITS] = dots;
        return {1'b0, word};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_conv(input logic [IN_BITS-1:0] value, input logic [DIGITS-1:0] dots, input string tag);
        logic [OUT_W:0] exp;
        int n;
        int busy_n;
        exp = model(int'(value), dots);
        bin_in  = value;
        dots_in = dots;
        start   = 1'b1;
        step();
        start   = 1'b0;
        bin_in  = IN_BITS'($urandom);
        dots_in = DIGITS'($urandom);
        n = 0;
        busy_n = 0;
        while (!done && n < BUDGET) begin
            if (busy) busy_n++;
            step();
            n++;
        end
        checks++;
        if (n !== LATENCY) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", tag, n, LATENCY);
        end
        checks++;
        if (busy_n !== LATENCY) begin
            failures++;
            $display("FAIL %s busy_len: got %0d cycles, expected %0d", tag, busy_n, LATENCY);
        end
        checks++;
        if (data_out !== exp[OUT_W-1:0]) begin
            failures++;
            $display("FAIL %s data_out: got %h, expected %h (value %0d)", tag, data_out, exp[OUT_W-1:0], value);
        end
        checks++;
        if (ovf !== exp[OUT_W]) begin
            failures++;
            $display("FAIL %s ovf: got %b, expected %b (value %0d)", tag, ovf, exp[OUT_W], value);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_at_done: got %b, expected 0", tag, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || data_out !== exp[OUT_W-1:0]) begin
            failures++;
            $display("FAIL %s hold: got done=%b data=%h, expected done=0 data=%h", tag, done, data_out, exp[OUT_W-1:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, done, ovf, data_out} !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b ovf=%b data=%h, expected all 0", busy, done, ovf, data_out);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy, done, ovf, data_out} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle: got busy=%b done=%b ovf=%b data=%h, expected all 0", busy, done, ovf, data_out);
        end
    endtask

    task automatic test_basic();
        run_conv(14'd1234, 4'b0100, "basic_1234");
        checks++;
        if (data_out !== 20'h41234) begin
            failures++;
            $display("FAIL basic_literal: got %h, expected 41234", data_out);
        end
    endtask

    task automatic test_boundaries();
        run_conv(14'd0,     4'b0000, "zero");
        run_conv(14'd9999,  4'b0000, "max_val");
        run_conv(14'd10000, 4'b0011, "ovf_10000");
        run_conv(14'd16383, 4'b0000, "ovf_16383");
    endtask

    task automatic test_random();
        logic [IN_BITS-1:0] v;
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) v = IN_BITS'($urandom_range(9990, 10010));
            else            v = IN_BITS'($urandom_range(0, 16383));
            run_conv(v, DIGITS'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_ignore_start();
        logic [OUT_W:0] exp;
        int dones;
        exp = model(42, 4'b0000);
        bin_in  = 14'd42;
        dots_in = 4'b0000;
        start   = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        for (int i = 1; i <= LATENCY; i++) begin
            if (i == 3 || i == 14 || i == 15) begin
                start  = 1'b1;
                bin_in = 14'd77;
            end else begin
                start = 1'b0;
            end
            step();
            if (done) dones++;
        end
        start = 1'b0;
        checks++;
        if (data_out !== exp[OUT_W-1:0]) begin
            failures++;
            $display("FAIL ignore_data: got %h, expected %h", data_out, exp[OUT_W-1:0]);
        end
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step();
            if (done) dones++;
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d pulses, expected 1", dones);
        end
        checks++;
        if (data_out !== exp[OUT_W-1:0]) begin
            failures++;
            $display("FAIL ignore_held: got %h, expected %h", data_out, exp[OUT_W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [OUT_W:0] exp_a, exp_b;
        int n;
        int m;
        int extra;
        exp_a = model(5, 4'b1010);
        exp_b = model(6, 4'b0001);
        bin_in  = 14'd5;
        dots_in = 4'b1010;
        start   = 1'b1;
        step();
        bin_in  = 14'd6;
        dots_in = 4'b0001;
        n = 0;
        while (!done && n < BUDGET) begin
            step();
            n++;
        end
        checks++;
        if (n !== LATENCY || data_out !== exp_a[OUT_W-1:0]) begin
            failures++;
            $display("FAIL b2b_first: got %0d cycles data=%h, expected %0d cycles data=%h", n, data_out, LATENCY, exp_a[OUT_W-1:0]);
        end
        m = 0;
        do begin
            step();
            m++;
        end while (!done && m < BUDGET);
        start = 1'b0;
        checks++;
        if (m !== PERIOD) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles between done pulses, expected %0d", m, PERIOD);
        end
        checks++;
        if (data_out !== exp_b[OUT_W-1:0]) begin
            failures++;
            $display("FAIL b2b_second: got %h, expected %h", data_out, exp_b[OUT_W-1:0]);
        end
        extra = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step();
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL b2b_no_queue: got %0d extra done pulses, expected 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        run_conv(14'd16383, 4'b0101, "pre_abort_ovf");
        bin_in  = 14'd8765;
        dots_in = 4'b1111;
        start   = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, ovf, data_out} !== '0) begin
            failures++;
            $display("FAIL abort_async: got busy=%b done=%b ovf=%b data=%h, expected all 0", busy, done, ovf, data_out);
        end
        step();
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            step();
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", dones);
        end
        run_conv(14'd31, 4'b0000, "after_abort_31");
        checks++;
        if (data_out !== 20'h00031) begin
            failures++;
            $display("FAIL after_abort_literal: got %h, expected 00031", data_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the 4-digit multiplexed 7-segment driver.
- Produces the driver's packed 20-bit word: {dots[3:0], bcd[15:0]}.
- Lets counters and LFSR values be shown as decimal instead of hex. Uses a start/busy/done handshake; one conversion is in flight at a time.

Parameters:
- IN_BITS, 14, width of the binary input; 14 bits covers 0..9999 plus overflow range.
- DIGITS, 4, number of BCD digits and dot bits; output width is 5*DIGITS.
- MAX_VAL, 9999, largest displayable value; must equal 10**DIGITS - 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin_in  in  IN_BITS  binary value; captured on the accepting edge.
- dots_in  in  DIGITS  decimal-point mask; captured with bin_in; bit i lights digit i.
- busy  out  1  high from the accepting edge until the commit edge.
- done  out  1  one-cycle pulse; data_out is valid and new in that cycle.
- ovf  out  1  registered with data_out; 1 when the last captured value > MAX_VAL.
- data_out  out  5*DIGITS  {dots, bcd}; digit i in bits [4i+3:4i]; dot i in bit 4*DIGITS+i. Held until the next commit.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, busy=0, done=0, ovf=0, data_out=0.
  - Shift register and iteration counter are cleared.
  - A conversion in progress is aborted with no done pulse.
  - The first start after rst_n rises is accepted normally.
- States: IDLE, SHIFT, COMMIT.
- IDLE:
  - Edge with start=1 (call it edge k): capture bin_in into the binary shift register and dots_in into the dot register.
  - At edge k: clear the BCD accumulator, set cnt=0, set ovf_pending = (bin_in > MAX_VAL), set busy=1, go to SHIFT.
- SHIFT: on each edge,
  - Every BCD digit >= 5 gets +3 (all digits in parallel, same cycle).
  - Then {bcd, bin} shifts left by 1 and cnt increments.
  - After IN_BITS shifts (edges k+1..k+IN_BITS), go to COMMIT.
- COMMIT, edge k+IN_BITS+1:
  - data_out = {dots_reg, bcd}, or {dots forced all-1, every digit 4'hE} when ovf_pending.
  - ovf = ovf_pending; done=1 for exactly the following cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle after edge k+IN_BITS+1 (15 edges for the default parameters). The latency is fixed and does not depend on the input value or on overflow.
- start is ignored while busy=1, including the COMMIT cycle. A held start therefore does not queue a request.
- start=1 in the cycle where done=1 is accepted, because state is already IDLE. Back-to-back throughput is one conversion per IN_BITS+2 cycles.
- bin_in and dots_in may change freely after the accepting edge.
- Width rules:
  - BCD accumulator is 4*DIGITS bits.
  - Add-3 is 4-bit with no carry out; this is legal because adjusted digits are <= 12.
  - Counter width is clog2(IN_BITS+1).
- With IN_BITS=14, values 10000..16383 never reach the shift stage with a meaningful result. The overflow override always wins.

Decomposition:
- Shared display package holds:
  - constants DIGIT_ERR=4'hE and DIGIT_W=4;
  - state encoding localparams IDLE/SHIFT/COMMIT;
  - a function computing the packed display width 5*DIGITS.
- One sub-module: bcd_digit_adj. It is combinational, 4-bit in and 4-bit out (d>=5 ? d+3 : d), instantiated DIGITS times by generate.

Test Plan:
- Reset, then bin_in=1234, dots_in=4'b0100, start one cycle:
  - done after 15 edges;
  - data_out=20'h41234, ovf=0;
  - busy high for exactly 15 cycles.
- bin_in=0, dots=0 -> data_out=20'h00000. Then bin_in=9999 -> data_out=20'h09999, ovf=0.
- bin_in=10000, then bin_in=16383 -> data_out=20'hFEEEE and ovf=1 for both, with the same latency as a normal conversion.
- Start 42; pulse start with bin_in=77 at cycles 3 and 14 of the conversion -> both ignored; data_out=20'h00042; exactly one done pulse.
- start held high continuously with bin_in=5, then 6 -> conversions are back-to-back. Each request is accepted on the cycle its predecessor's done is high; a done pulse occurs every 16 cycles.
- Drop rst_n at shift 7 of a conversion of 8765 -> outputs are 0 immediately with no done pulse. After release, converting 31 gives data_out=20'h00031.
